// File: rtl/mult36_pkg.sv
// Shared constants, helper function and response bundle for the 36x36+72 multiply scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: operand/result widths, clog2, rsp_t {id, result}.
package mult36_pkg;

  localparam int MULT_AW = 36;   // A/B operand width
  localparam int MULT_CW = 72;   // C addend width
  localparam int MULT_RW = 73;   // result width
  localparam int MAX_IDW = 3;    // widest requester tag (up to 8 requesters)

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  typedef struct packed {
    logic [MAX_IDW-1:0] id;
    logic [MULT_RW-1:0] result;
  } rsp_t;

endpackage

// File: rtl/mult36x36p72.sv
// Signed 36x36 multiply plus signed 72-bit addend, full-precision 73-bit signed result.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a, b signed operands; c signed addend; r = sext73(a*b) + sext73(c).
module mult36x36p72
  import mult36_pkg::*;
(
  input  logic signed [MULT_AW-1:0] a,
  input  logic signed [MULT_AW-1:0] b,
  input  logic        [MULT_CW-1:0] c,
  output logic        [MULT_RW-1:0] r
);

  logic signed [MULT_CW-1:0] prod;

  // 36x36 signed product always fits in 72 bits; one extra bit absorbs the add carry.
  assign prod = a * b;
  assign r    = {prod[MULT_CW-1], prod} + {c[MULT_CW-1], c};

endmodule

// File: rtl/rr_arb_onehot.sv
// Round-robin one-hot arbiter: grants the first asserted req at or above ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; caller qualifies the grant with its own load condition.
// Ports: req[N] requests, ptr[W] highest-priority index, grant[N] one-hot or zero.
module rr_arb_onehot
  import mult36_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant
);

  int best_d;
  int d;

  // Pick the requester with the smallest circular distance from ptr.
  always_comb begin
    grant  = '0;
    best_d = N;
    d      = 0;
    for (int i = 0; i < N; i++) begin
      d = i - int'(ptr);
      if (d < 0) d = d + N;
      if (req[i] && (d < best_d)) begin
        best_d   = d;
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult36_rr_sched.sv
// Shares one mult36x36p72 among NREQ valid/ready requesters with round-robin arbitration.
// Latency: request handshaken in cycle k yields rsp_valid in cycle k+2; one op per cycle sustained.
// Backpressure: rsp_ready low stalls S2, S1 fills once more, then all req_ready drop to 0.
// Ports: clk, resetn (async, active-low); req_valid/req_ready/req_a/req_b/req_c per requester
//        (flattened, requester i at slice i); rsp_valid/rsp_ready/rsp_id/rsp_result; busy.
module mult36_rr_sched
  import mult36_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*MULT_AW-1:0]   req_a,
  input  logic [NREQ*MULT_AW-1:0]   req_b,
  input  logic [NREQ*MULT_CW-1:0]   req_c,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [MULT_RW-1:0]        rsp_result,
  output logic                      busy
);

  logic [NREQ-1:0]    grant;
  logic               adv_s2;
  logic               load_s1;
  logic               accept;
  logic [IDW-1:0]     g_idx;
  logic [MULT_AW-1:0] sel_a;
  logic [MULT_AW-1:0] sel_b;
  logic [MULT_CW-1:0] sel_c;
  logic [MULT_RW-1:0] mult_r;

  logic               s1_v_q,   s1_v_d;
  logic [MULT_AW-1:0] s1_a_q,   s1_a_d;
  logic [MULT_AW-1:0] s1_b_q,   s1_b_d;
  logic [MULT_CW-1:0] s1_c_q,   s1_c_d;
  logic [IDW-1:0]     s1_id_q,  s1_id_d;
  logic               s2_v_q,   s2_v_d;
  logic [IDW-1:0]     s2_id_q,  s2_id_d;
  logic [MULT_RW-1:0] s2_res_q, s2_res_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;

  rr_arb_onehot #(
    .N (NREQ)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  // Single multiplier instance, fed straight from the S1 registers.
  mult36x36p72 u_mult (
    .a (s1_a_q),
    .b (s1_b_q),
    .c (s1_c_q),
    .r (mult_r)
  );

  always_comb begin
    adv_s2    = !s2_v_q || rsp_ready;
    load_s1   = !s1_v_q || adv_s2;
    // Ready is gated by resetn so nothing is accepted while flops are held in reset.
    req_ready = resetn ? (grant & {NREQ{load_s1}}) : '0;
    accept    = |(req_valid & req_ready);

    g_idx = '0;
    sel_a = '0;
    sel_b = '0;
    sel_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        g_idx = IDW'(i);
        sel_a = req_a[i*MULT_AW +: MULT_AW];
        sel_b = req_b[i*MULT_AW +: MULT_AW];
        sel_c = req_c[i*MULT_CW +: MULT_CW];
      end
    end

    s1_v_d   = s1_v_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s1_c_d   = s1_c_q;
    s1_id_d  = s1_id_q;
    s2_v_d   = s2_v_q;
    s2_id_d  = s2_id_q;
    s2_res_d = s2_res_q;
    rr_ptr_d = rr_ptr_q;

    if (accept) begin
      rr_ptr_d = (g_idx == IDW'(NREQ-1)) ? '0 : g_idx + IDW'(1);
    end

    if (load_s1) begin
      s1_v_d = accept;
      if (accept) begin
        s1_a_d  = sel_a;
        s1_b_d  = sel_b;
        s1_c_d  = sel_c;
        s1_id_d = g_idx;
      end
    end

    // S2 data only moves with a real operation so rsp_* stays quiet across bubbles.
    if (adv_s2) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_id_d  = s1_id_q;
        s2_res_d = mult_r;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_v_q   <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_c_q   <= '0;
      s1_id_q  <= '0;
      s2_v_q   <= 1'b0;
      s2_id_q  <= '0;
      s2_res_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      s1_v_q   <= s1_v_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s1_c_q   <= s1_c_d;
      s1_id_q  <= s1_id_d;
      s2_v_q   <= s2_v_d;
      s2_id_q  <= s2_id_d;
      s2_res_q <= s2_res_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rsp_valid  = s2_v_q;
  assign rsp_id     = s2_id_q;
  assign rsp_result = s2_res_q;
  assign busy       = s1_v_q | s2_v_q;

endmodule

// File: tb/tb_mult36_rr_sched.sv
// Directed and random bench for mult36_rr_sched with an in-order scoreboard.
// Latency: checks rsp two cycles after handshake.
// Backpressure: exercises rsp_ready stalls and random rsp_ready.
module tb_mult36_rr_sched;
  import mult36_pkg::*;

  localparam int NREQ         = 4;
  localparam int IDW          = clog2(NREQ);
  localparam int N_SOAK       = 12000;
  localparam int SOAK_MAX_CYC = 40000;

  logic                    clk = 1'b0;
  logic                    resetn;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*MULT_AW-1:0] req_a;
  logic [NREQ*MULT_AW-1:0] req_b;
  logic [NREQ*MULT_CW-1:0] req_c;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IDW-1:0]          rsp_id;
  logic [MULT_RW-1:0]      rsp_result;
  logic                    busy;

  int              n_vec = 0;
  int              n_err = 0;
  int              n_acc = 0;
  logic [NREQ-1:0] acc_mask = '0;
  logic            auto_drop = 1'b0;
  rsp_t            sb_q[$];
  int              wait_acc [NREQ];

  logic [NREQ-1:0]    fair_all [8] = '{4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4};
  logic [NREQ-1:0]    fair_02  [4] = '{4'h1, 4'h4, 4'h1, 4'h4};
  int                 bp_order [4] = '{3, 0, 1, 2};
  logic [MULT_AW-1:0] bp_a [NREQ];
  logic [MULT_AW-1:0] bp_b [NREQ];
  logic [MULT_CW-1:0] bp_c [NREQ];

  mult36_rr_sched #(
    .NREQ (NREQ)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_c      (req_c),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [MULT_RW-1:0] got, input logic [MULT_RW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  function automatic logic [MULT_RW-1:0] mac(input logic [MULT_AW-1:0] a, input logic [MULT_AW-1:0] b,
                                            input logic [MULT_CW-1:0] c);
    logic signed [MULT_RW-1:0] ae, be, ce;
    ae = {{(MULT_RW-MULT_AW){a[MULT_AW-1]}}, a};
    be = {{(MULT_RW-MULT_AW){b[MULT_AW-1]}}, b};
    ce = {c[MULT_CW-1], c};
    return ae * be + ce;
  endfunction

  function automatic logic [MULT_AW-1:0] rnd36();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0:       return 36'h8_0000_0000;
      1:       return 36'h7_FFFF_FFFF;
      2:       return 36'hF_FFFF_FFFF;
      default: return r[MULT_AW-1:0];
    endcase
  endfunction

  function automatic logic [MULT_CW-1:0] rnd72();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    case ($urandom_range(0, 7))
      0:       return {1'b1, 71'h0};
      1:       return {1'b0, {71{1'b1}}};
      default: return r[MULT_CW-1:0];
    endcase
  endfunction

  task automatic set_req(input int i, input logic [MULT_AW-1:0] a, input logic [MULT_AW-1:0] b,
                         input logic [MULT_CW-1:0] c);
    req_valid[i]                  = 1'b1;
    req_a[i*MULT_AW +: MULT_AW]   = a;
    req_b[i*MULT_AW +: MULT_AW]   = b;
    req_c[i*MULT_CW +: MULT_CW]   = c;
  endtask

  // Advance to just after the next rising edge; optionally retire accepted requests.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (auto_drop) req_valid = req_valid & ~acc_mask;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy || rsp_valid) && n < 50) begin
      cyc();
      n++;
    end
    #1;
    chk("drain_idle", busy, 0);
  endtask

  // Scoreboard: record handshakes and responses half a cycle before the edge that commits them.
  always @(negedge clk) begin : mon
    rsp_t e;
    acc_mask = '0;
    if (!resetn) begin
      sb_q.delete();
      for (int i = 0; i < NREQ; i++) wait_acc[i] = 0;
    end else begin
      acc_mask = req_valid & req_ready;
      if (acc_mask != '0) begin
        n_acc++;
        chk("ready_onehot", $countones(acc_mask), 1);
        for (int i = 0; i < NREQ; i++) begin
          if (acc_mask[i]) begin
            e.id     = MAX_IDW'(i);
            e.result = mac(req_a[i*MULT_AW +: MULT_AW], req_b[i*MULT_AW +: MULT_AW],
                           req_c[i*MULT_CW +: MULT_CW]);
            sb_q.push_back(e);
            chk("starve", wait_acc[i] < NREQ, 1);
            wait_acc[i] = 0;
          end else if (req_valid[i]) begin
            wait_acc[i]++;
          end
        end
      end
      for (int i = 0; i < NREQ; i++) if (!req_valid[i]) wait_acc[i] = 0;
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          chk("stale_rsp", rsp_valid, 0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_id", rsp_id, e.id);
          chk("sb_res", rsp_result, e.result);
        end
      end
    end
  end

  initial begin
    int n0;
    int soak_cyc;
    resetn    = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    rsp_ready = 1'b1;

    // Reset with every requester asking.
    for (int i = 0; i < NREQ; i++) set_req(i, MULT_AW'(i + 3), MULT_AW'(i + 5), MULT_CW'(i));
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_result", rsp_result, 0);
    end
    resetn = 1'b1;
    #1;
    chk("first_grant", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    drain();

    // Single op: -1 * -1 + 0 from requester 1.
    set_req(1, 36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, 72'h0);
    #1;
    chk("single_grant", req_ready, 4'b0010);
    cyc();
    req_valid = '0;
    #1;
    chk("single_early_vld", rsp_valid, 0);
    cyc();
    #1;
    chk("single_vld", rsp_valid, 1);
    chk("single_id", rsp_id, 1);
    chk("single_res", rsp_result, 73'h1);
    drain();

    // Corner values back to back from requester 2.
    set_req(2, 36'h8_0000_0000, 36'h8_0000_0000, 72'h0);
    #1;
    chk("corner1_grant", req_ready, 4'b0100);
    cyc();
    set_req(2, 36'h7_FFFF_FFFF, 36'h7_FFFF_FFFF, 72'hFF_FFFF_FFFF_FFFF_FFFF);
    #1;
    chk("corner2_grant", req_ready, 4'b0100);
    cyc();
    req_valid = '0;
    #1;
    chk("corner1_vld", rsp_valid, 1);
    chk("corner1_id", rsp_id, 2);
    chk("corner1_res", rsp_result, 73'h0_40_0000_0000_0000_0000);
    cyc();
    #1;
    chk("corner2_vld", rsp_valid, 1);
    chk("corner2_id", rsp_id, 2);
    chk("corner2_res", rsp_result, 73'h0_3F_FFFF_FFF0_0000_0000);
    drain();

    // Fairness: pointer sits at 3 after the corner ops.
    for (int i = 0; i < NREQ; i++) set_req(i, MULT_AW'(i + 1), MULT_AW'(3 * i + 2), MULT_CW'(i));
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("fair_all", req_ready, fair_all[k]);
      cyc();
    end
    req_valid = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("fair_02", req_ready, fair_02[k]);
      cyc();
    end
    req_valid = '0;
    drain();

    // Backpressure: four one-shot requests, response channel stalled for five cycles.
    rsp_ready = 1'b0;
    auto_drop = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      bp_a[i] = 36'h9_0000_0000 | MULT_AW'(i);
      bp_b[i] = MULT_AW'(i + 7);
      bp_c[i] = {MULT_CW{1'b1}};
      set_req(i, bp_a[i], bp_b[i], bp_c[i]);
    end
    n0 = n_acc;
    #1;
    chk("bp_grant0", req_ready, 4'b1000);
    cyc();
    #1;
    chk("bp_grant1", req_ready, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1;
      chk("bp_ready", req_ready, 0);
      chk("bp_vld", rsp_valid, 1);
      chk("bp_id", rsp_id, 3);
      chk("bp_res", rsp_result, mac(bp_a[3], bp_b[3], bp_c[3]));
    end
    chk("bp_accepts", n_acc - n0, 2);
    cyc();
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_rel_vld", rsp_valid, 1);
      chk("bp_rel_id", rsp_id, bp_order[k]);
      chk("bp_rel_res", rsp_result, mac(bp_a[bp_order[k]], bp_b[bp_order[k]], bp_c[bp_order[k]]));
      cyc();
    end
    chk("bp_all_taken", req_valid, 0);
    auto_drop = 1'b0;
    drain();

    // Random soak with random response backpressure and a reset pulse part way through.
    n0       = n_acc;
    soak_cyc = 0;
    while ((n_acc - n0) < N_SOAK && soak_cyc < SOAK_MAX_CYC) begin
      for (int i = 0; i < NREQ; i++) begin
        if (acc_mask[i] || !req_valid[i]) begin
          if ($urandom_range(0, 3) != 0) set_req(i, rnd36(), rnd36(), rnd72());
          else req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (soak_cyc == 3000) begin
        resetn = 1'b0;
        #1;
        chk("soak_rst_busy", busy, 0);
        chk("soak_rst_vld", rsp_valid, 0);
        chk("soak_rst_ready", req_ready, 0);
      end
      if (soak_cyc == 3002) resetn = 1'b1;
      cyc();
      soak_cyc++;
    end
    chk("soak_done", (n_acc - n0) >= N_SOAK, 1);
    req_valid = '0;
    rsp_ready = 1'b1;
    drain();
    chk("sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
